// File: rtl/countdown_timer_if.sv
// Bus between the game controller and the countdown timer.
//   master : game controller side (bonus pulses, frame strobe, play gate)
//   slave  : countdown timer side (BCD digits, expiry, low-time warning)
// Handshake: add_time and startOfFrame are single-cycle strobes with no
// back-pressure; the timer samples them on every rising clk edge, so
// each cycle a strobe is high counts as one event. Outputs are level
// signals and are valid in every cycle.
interface countdown_timer_if;
  logic            startOfFrame;
  logic            add_time;
  logic [1:0][3:0] time_to_add;
  logic            player_active;
  logic [1:0][3:0] time_digits;
  logic            out_of_time;
  logic            low_time;

  modport master (
    output startOfFrame, add_time, time_to_add, player_active,
    input  time_digits, out_of_time, low_time
  );

  modport slave (
    input  startOfFrame, add_time, time_to_add, player_active,
    output time_digits, out_of_time, low_time
  );
endinterface

// File: rtl/countdown_timer.sv
// Two-digit BCD game countdown timer.
// Decrements once every FRAMES_PER_SECOND startOfFrame pulses while the
// player is active, accepts bonus time from the controller, saturates at
// 99, floors at 00 and latches out_of_time when a decrement reaches 00.
// Optional feature macro: COUNTDOWN_LOW_BLINK_EN (blinks low_time with a
// half-period of BLINK_FRAMES frames); when undefined low_time is steady.
module countdown_timer #(
  parameter int         FRAMES_PER_SECOND  = 30,
  parameter logic [3:0] INITIAL_TENS       = 4'h9,
  parameter logic [3:0] INITIAL_ONES       = 4'h9,
  parameter int         LOW_TIME_THRESHOLD = 10,
  parameter int         BLINK_FRAMES       = 8
) (
  input  logic               clk,
  input  logic               resetN,
  countdown_timer_if.slave   tmr
);

  localparam int             FCW     = (FRAMES_PER_SECOND > 2) ? $clog2(FRAMES_PER_SECOND) : 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_SECOND - 1);
  localparam logic [6:0]     LOW_THR = 7'(LOW_TIME_THRESHOLD);

  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]     tens_q, tens_d;
  logic [3:0]     ones_q, ones_d;
  logic           oot_q, oot_d;

  logic           running;
  logic           tick;
  logic [3:0]     add_tens, add_ones;
  logic [6:0]     cur_val, add_val;
  logic [7:0]     sum_val, dec_val;
  logic [6:0]     next_val;
  logic           low_cond;

  assign running = !oot_q && tmr.player_active;
  assign tick    = running && tmr.startOfFrame && (frame_cnt_q == FC_LAST);

  // Out-of-range BCD digits from the controller are treated as 9.
  assign add_tens = (tmr.time_to_add[1] > 4'd9) ? 4'd9 : tmr.time_to_add[1];
  assign add_ones = (tmr.time_to_add[0] > 4'd9) ? 4'd9 : tmr.time_to_add[0];

  // Arithmetic is done in binary 0..99; the stored digits are always valid BCD.
  assign cur_val = 7'(tens_q) * 7'd10 + 7'(ones_q);
  assign add_val = tmr.add_time ? (7'(add_tens) * 7'd10 + 7'(add_ones)) : 7'd0;
  assign sum_val = {1'b0, cur_val} + {1'b0, add_val};

  // Apply the add and the tick together; floor at 0 and saturate at 99.
  always_comb begin
    dec_val  = sum_val;
    next_val = 7'd0;
    if (tick && (sum_val != 8'd0)) begin
      dec_val = sum_val - 8'd1;
    end
    if (dec_val > 8'd99) begin
      next_val = 7'd99;
    end else begin
      next_val = dec_val[6:0];
    end
  end

  // Next-state for the frame counter, digits and the sticky expiry flag.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    oot_d       = oot_q;
    if (running && tmr.startOfFrame) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = frame_cnt_q + FCW'(1);
      end
    end
    if (!oot_q) begin
      tens_d = 4'(next_val / 7'd10);
      ones_d = 4'(next_val % 7'd10);
      oot_d  = tick && (next_val == 7'd0);
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt_q <= '0;
      tens_q      <= INITIAL_TENS;
      ones_q      <= INITIAL_ONES;
      oot_q       <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      oot_q       <= oot_d;
    end
  end

  assign low_cond = (cur_val <= LOW_THR) && !oot_q;

`ifdef COUNTDOWN_LOW_BLINK_EN
  localparam int             BCW     = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BCW-1:0] BC_LAST = BCW'(BLINK_FRAMES - 1);

  logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_q, blink_d;

  // Blink phase advances per frame while low; anything else restarts it dark.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (!low_cond) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (tmr.startOfFrame) begin
      if (blink_cnt_q == BC_LAST) begin
        blink_cnt_d = '0;
        blink_d     = !blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BCW'(1);
      end
    end
  end

  // Blink state registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign tmr.low_time = low_cond && blink_q;
`else
  assign tmr.low_time = low_cond;
`endif

  assign tmr.time_digits = {tens_q, ones_q};
  assign tmr.out_of_time = oot_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer in its default build
// (FRAMES_PER_SECOND=30, initial value 99, threshold 10, no blink).
module tb_countdown_timer;

  logic clk;
  logic resetN;
  int   total;
  int   bad;

  countdown_timer_if tif();

  countdown_timer dut (
    .clk    (clk),
    .resetN (resetN),
    .tmr    (tif.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: n back-to-back startOfFrame pulses; returns 1 ns after the last edge.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      tif.startOfFrame = 1'b1;
      @(posedge clk);
      #1;
    end
    tif.startOfFrame = 1'b0;
  endtask

  // Driver: one add_time pulse with the given digits.
  task automatic add(input logic [3:0] t, input logic [3:0] o);
    tif.add_time    = 1'b1;
    tif.time_to_add = {t, o};
    @(posedge clk);
    #1;
    tif.add_time    = 1'b0;
    tif.time_to_add = '0;
  endtask

  task automatic test_reset;
    total++; if (tif.time_digits !== 8'h99) begin bad++; $display("FAIL rst_digits: got %h want 99", tif.time_digits); end
    total++; if (tif.out_of_time !== 1'b0) begin bad++; $display("FAIL rst_oot: got %b want 0", tif.out_of_time); end
    total++; if (tif.low_time !== 1'b0) begin bad++; $display("FAIL rst_low: got %b want 0", tif.low_time); end
  endtask

  task automatic test_decrement;
    frames(29);
    total++; if (tif.time_digits !== 8'h99) begin bad++; $display("FAIL dec_29: got %h want 99", tif.time_digits); end
    frames(1);
    total++; if (tif.time_digits !== 8'h98) begin bad++; $display("FAIL dec_30: got %h want 98", tif.time_digits); end
    total++; if (tif.out_of_time !== 1'b0) begin bad++; $display("FAIL dec_oot: got %b want 0", tif.out_of_time); end
  endtask

  task automatic test_add;
    frames(90);
    total++; if (tif.time_digits !== 8'h95) begin bad++; $display("FAIL add_pre95: got %h want 95", tif.time_digits); end
    add(4'd1, 4'd0);
    total++; if (tif.time_digits !== 8'h99) begin bad++; $display("FAIL add_sat: got %h want 99", tif.time_digits); end
    frames(62 * 30);
    total++; if (tif.time_digits !== 8'h37) begin bad++; $display("FAIL add_pre37: got %h want 37", tif.time_digits); end
    add(4'd1, 4'd0);
    total++; if (tif.time_digits !== 8'h47) begin bad++; $display("FAIL add_47: got %h want 47", tif.time_digits); end
    add(4'd0, 4'hF);
    total++; if (tif.time_digits !== 8'h56) begin bad++; $display("FAIL add_clamp_ones: got %h want 56", tif.time_digits); end
  endtask

  task automatic test_pause;
    frames(6 * 30);
    total++; if (tif.time_digits !== 8'h50) begin bad++; $display("FAIL pause_pre50: got %h want 50", tif.time_digits); end
    frames(15);
    tif.player_active = 1'b0;
    frames(100);
    total++; if (tif.time_digits !== 8'h50) begin bad++; $display("FAIL pause_hold: got %h want 50", tif.time_digits); end
    add(4'd0, 4'd2);
    total++; if (tif.time_digits !== 8'h52) begin bad++; $display("FAIL pause_add: got %h want 52", tif.time_digits); end
    tif.player_active = 1'b1;
    frames(14);
    total++; if (tif.time_digits !== 8'h52) begin bad++; $display("FAIL resume_14: got %h want 52", tif.time_digits); end
    frames(1);
    total++; if (tif.time_digits !== 8'h51) begin bad++; $display("FAIL resume_15: got %h want 51", tif.time_digits); end
  endtask

  task automatic test_low_time;
    frames(40 * 30);
    total++; if (tif.time_digits !== 8'h11) begin bad++; $display("FAIL low_pre11: got %h want 11", tif.time_digits); end
    total++; if (tif.low_time !== 1'b0) begin bad++; $display("FAIL low_at11: got %b want 0", tif.low_time); end
    frames(30);
    total++; if (tif.time_digits !== 8'h10) begin bad++; $display("FAIL low_pre10: got %h want 10", tif.time_digits); end
    total++; if (tif.low_time !== 1'b1) begin bad++; $display("FAIL low_at10: got %b want 1", tif.low_time); end
    add(4'd1, 4'd0);
    total++; if (tif.time_digits !== 8'h20) begin bad++; $display("FAIL low_add20: got %h want 20", tif.time_digits); end
    total++; if (tif.low_time !== 1'b0) begin bad++; $display("FAIL low_at20: got %b want 0", tif.low_time); end
  endtask

  task automatic test_expiry;
    frames(19 * 30);
    total++; if (tif.time_digits !== 8'h01) begin bad++; $display("FAIL exp_pre01: got %h want 01", tif.time_digits); end
    frames(29);
    // 30th frame and a +5 bonus in the same cycle: 01 - 1 + 5 = 05
    tif.startOfFrame = 1'b1;
    tif.add_time     = 1'b1;
    tif.time_to_add  = {4'd0, 4'd5};
    @(posedge clk);
    #1;
    tif.startOfFrame = 1'b0;
    tif.add_time     = 1'b0;
    tif.time_to_add  = '0;
    total++; if (tif.time_digits !== 8'h05) begin bad++; $display("FAIL exp_rescue: got %h want 05", tif.time_digits); end
    total++; if (tif.out_of_time !== 1'b0) begin bad++; $display("FAIL exp_rescue_oot: got %b want 0", tif.out_of_time); end
    total++; if (tif.low_time !== 1'b1) begin bad++; $display("FAIL exp_low05: got %b want 1", tif.low_time); end
    add(4'hC, 4'd0);
    total++; if (tif.time_digits !== 8'h95) begin bad++; $display("FAIL exp_clamp_tens: got %h want 95", tif.time_digits); end
    frames(94 * 30);
    total++; if (tif.time_digits !== 8'h01) begin bad++; $display("FAIL exp_back01: got %h want 01", tif.time_digits); end
    frames(29);
    total++; if (tif.out_of_time !== 1'b0) begin bad++; $display("FAIL exp_oot_early: got %b want 0", tif.out_of_time); end
    frames(1);
    total++; if (tif.time_digits !== 8'h00) begin bad++; $display("FAIL exp_00: got %h want 00", tif.time_digits); end
    total++; if (tif.out_of_time !== 1'b1) begin bad++; $display("FAIL exp_oot: got %b want 1", tif.out_of_time); end
    total++; if (tif.low_time !== 1'b0) begin bad++; $display("FAIL exp_low: got %b want 0", tif.low_time); end
    add(4'd1, 4'd0);
    total++; if (tif.time_digits !== 8'h00) begin bad++; $display("FAIL exp_add_ignored: got %h want 00", tif.time_digits); end
    frames(60);
    total++; if (tif.time_digits !== 8'h00) begin bad++; $display("FAIL exp_hold: got %h want 00", tif.time_digits); end
    total++; if (tif.out_of_time !== 1'b1) begin bad++; $display("FAIL exp_sticky: got %b want 1", tif.out_of_time); end
  endtask

  task automatic test_reset_mid;
    resetN = 1'b0;
    #2;
    total++; if (tif.time_digits !== 8'h99) begin bad++; $display("FAIL rmid_digits: got %h want 99", tif.time_digits); end
    total++; if (tif.out_of_time !== 1'b0) begin bad++; $display("FAIL rmid_oot: got %b want 0", tif.out_of_time); end
    #2;
    resetN = 1'b1;
    @(posedge clk);
    #1;
    frames(29);
    total++; if (tif.time_digits !== 8'h99) begin bad++; $display("FAIL rmid_cnt29: got %h want 99", tif.time_digits); end
    frames(1);
    total++; if (tif.time_digits !== 8'h98) begin bad++; $display("FAIL rmid_cnt30: got %h want 98", tif.time_digits); end
  endtask

  initial begin
    total             = 0;
    bad               = 0;
    resetN            = 1'b0;
    tif.startOfFrame  = 1'b0;
    tif.add_time      = 1'b0;
    tif.time_to_add   = '0;
    tif.player_active = 1'b1;
    #12;
    resetN = 1'b1;
    @(posedge clk);
    #1;
    test_reset;
    test_decrement;
    test_add;
    test_pause;
    test_low_time;
    test_expiry;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
